gnrl_rr_arb_lock: RTL and testbench
===================================

# gnrl_rr_arb_lock

Parametrised N-way round-robin arbiter with locked (multi-cycle) grants for shared-resource access in the general library. A winner holds its grant until it signals end of access, withdraws its request, or exceeds a programmable hold limit. Grants are registered and re-arbitrated with no idle cycle between holders. Used in front of shared buses and ports wherever more than three masters contend.

## Interface
- N, 4: number of requesters; legal range 2 to 32.
- MAX_HOLD, 0: maximum grant length in cycles; 0 disables preemption. Legal range 0 to 65535.
- IDXW, $clog2(N) (minimum 1): width of the grant index output.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- i_req_vec  input  N  per-requester access request; level, held for the whole access.
- i_end_access_vec  input  N  per-requester end-of-access strobe; only the bit of the current holder is honoured.
- o_gnt_vec  output  N  registered one-hot grant, or all zero.
- o_gnt_idx  output  IDXW  binary index of the holder; valid only when o_gnt_vld=1.
- o_gnt_vld  output  1  equals |o_gnt_vec.
- o_preempt  output  1  one-cycle pulse, registered; the grant was revoked by the hold limit.

## Operation
- State machine with states IDLE (no holder) and BUSY (one holder). Registers: state, gnt_vec, last_posn (index of the most recent winner), hold_cnt (16 bits), preempt.
- Reset values: state=IDLE, o_gnt_vec=0, o_gnt_idx=0, o_gnt_vld=0, o_preempt=0, last_posn=N-1, hold_cnt=0. Reset takes effect asynchronously, including in the middle of an access.
- Round-robin pick:
  - Search order is last_posn+1, last_posn+2, and so on, modulo N.
  - The first requester with i_req_vec set wins.
  - last_posn becomes the winner's index.
  - At reset, requester 0 has highest priority.
- IDLE:
  - Any i_req_vec bit set causes a pick. At the clock edge, gnt_vec takes the winner's one-hot value, state goes to BUSY and hold_cnt is cleared.
  - No request: outputs stay zero.
- BUSY: the holder h is released in any cycle where one of the following holds:
  - (a) i_end_access_vec[h]=1;
  - (b) i_req_vec[h]=0 (abandon);
  - (c) MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1. Preempt fires only if neither (a) nor (b) holds in that cycle.
- Release cycle behaviour:
  - The pick runs in the same cycle, with bit h masked out of the requests.
  - If another requester wins, gnt_vec switches directly to it at the edge, hold_cnt clears, and state stays BUSY.
  - If there is no other requester, gnt_vec goes to 0 and state goes to IDLE. This applies even if h is still requesting. h can be regranted in the following cycle.
- Not released: gnt_vec and last_posn hold. hold_cnt increments and saturates at 0xFFFF.
- End-access strobes from non-holders are ignored.
- Request changes from non-holders never disturb the current grant.
- o_preempt is set at the edge that ends a grant under condition (c). It clears on the next edge.
- o_gnt_idx is a registered binary encode of gnt_vec, updated on the same edge as gnt_vec.

## Timing
- Request to grant: 1 cycle. If i_req_vec is first set before edge k and the arbiter is IDLE, o_gnt_vec is valid after edge k.
- Handover: 0 bubble cycles. If end_access is seen before edge k, the next holder is granted after edge k.
- Release to idle: o_gnt_vec=0 after the edge that samples the release condition.
- Grant length with MAX_HOLD=M: the holder sees o_gnt_vec asserted for exactly M cycles. o_preempt is high during the first cycle of the following grant (or idle cycle).
- Simultaneous release and new request from the releasing holder: the holder loses for one pick. Starvation bound is N-1 grants.

## Test plan
- Reset priority (N=4, MAX_HOLD=0): i_req_vec=4'b1111 from reset. Expect grant order 0,1,2,3,0 as each holder pulses end_access one cycle after its grant appears. Each grant lasts 2 cycles with no gaps; o_gnt_idx tracks.
- Rotation skip: last winner is 1; i_req_vec=4'b1001. Expect grant to 3, then to 0 after 3 ends.
- Abandon and idle: the holder drops i_req_vec with no end_access and no other requester. Expect o_gnt_vec=0 and o_gnt_vld=0 after the next edge. Re-raising the request yields a grant 1 cycle later.
- Preempt (MAX_HOLD=8): requester 2 holds and never ends; requester 0 is requesting. Expect o_gnt_vec=4'b0100 for exactly 8 cycles, then 4'b0001, with o_preempt high for 1 cycle. With no other requester, expect 0 for one cycle, then requester 2 regranted.
- Foreign strobe: requester 1 holds; i_end_access_vec=4'b1000. Expect the grant unchanged and hold_cnt still incrementing.
- Async reset mid-access: assert rst_n=0 between edges while BUSY. Expect all outputs 0 immediately without a clock edge. After release, requester 0 has top priority.

Source files
------------

// File: rtl/gnrl_rr_arb_lock.sv
// gnrl_rr_arb_lock: N-way round-robin arbiter with locked multi-cycle grants.
// A holder keeps the grant until it strobes end-of-access, drops its request,
// or reaches the optional hold limit. Handover to the next winner happens on
// the release edge itself, so there is no idle cycle between holders.
module gnrl_rr_arb_lock #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 0,
    parameter int IDXW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    i_req_vec,
    input  logic [N-1:0]    i_end_access_vec,
    output logic [N-1:0]    o_gnt_vec,
    output logic [IDXW-1:0] o_gnt_idx,
    output logic            o_gnt_vld,
    output logic            o_preempt
);

    typedef enum logic {IDLE, BUSY} state_t;

    // Last cycle of a limited grant is the one where the counter reads MAX_HOLD-1.
    localparam logic [15:0]   HOLD_LIM = (MAX_HOLD == 0) ? 16'd0 : 16'(MAX_HOLD - 1);
    localparam logic [N-1:0]  ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(N - 1);

    state_t          r_state, w_state_nxt;
    logic [N-1:0]    r_gnt_vec, w_gnt_nxt;
    logic [IDXW-1:0] r_gnt_idx, w_idx_nxt;
    logic [IDXW-1:0] r_last_posn, w_last_nxt;
    logic [15:0]     r_hold_cnt, w_hold_nxt;
    logic            r_preempt, w_preempt_nxt;

    logic [N-1:0]    w_pick_req;
    logic [N-1:0]    w_pick_oh;
    logic [IDXW-1:0] w_pick_idx;
    logic [IDXW-1:0] w_scan;
    logic            w_pick_hit;
    logic            w_end;
    logic            w_abandon;
    logic            w_limit;
    logic            w_release;

    // Holder's own release conditions; only the holder's bits are looked at.
    assign w_end     = i_end_access_vec[r_gnt_idx];
    assign w_abandon = ~i_req_vec[r_gnt_idx];
    assign w_limit   = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LIM);
    assign w_release = w_end | w_abandon | w_limit;

    // While busy the pick only matters on release, and then the holder sits
    // out one round, so masking its bit unconditionally is safe.
    assign w_pick_req = (r_state == BUSY) ? (i_req_vec & ~r_gnt_vec) : i_req_vec;

    // Round-robin scan: walk from the farthest slot (last_posn itself) towards
    // last_posn+1 so the nearest requester is written last and wins.
    always_comb begin
        w_pick_hit = 1'b0;
        w_pick_idx = '0;
        w_scan     = '0;
        for (int k = N; k >= 1; k--) begin
            w_scan = IDXW'((int'(r_last_posn) + k) % N);
            if (w_pick_req[w_scan]) begin
                w_pick_hit = 1'b1;
                w_pick_idx = w_scan;
            end
        end
        w_pick_oh = ONE_HOT0 << w_pick_idx;
    end

    // Next-state and next-register values for the IDLE/BUSY controller.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt_vec;
        w_idx_nxt     = r_gnt_idx;
        w_last_nxt    = r_last_posn;
        w_hold_nxt    = r_hold_cnt;
        w_preempt_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_hit) begin
                    w_state_nxt = BUSY;
                    w_gnt_nxt   = w_pick_oh;
                    w_idx_nxt   = w_pick_idx;
                    w_last_nxt  = w_pick_idx;
                    w_hold_nxt  = '0;
                end
            end
            BUSY: begin
                if (w_release) begin
                    // Preempt is reported only when the limit alone ended the grant.
                    w_preempt_nxt = w_limit & ~w_end & ~w_abandon;
                    w_hold_nxt    = '0;
                    if (w_pick_hit) begin
                        w_gnt_nxt  = w_pick_oh;
                        w_idx_nxt  = w_pick_idx;
                        w_last_nxt = w_pick_idx;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_idx_nxt   = '0;
                    end
                end else if (r_hold_cnt != 16'hFFFF) begin
                    w_hold_nxt = r_hold_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt_vec   <= '0;
            r_gnt_idx   <= '0;
            r_last_posn <= LAST_RST;
            r_hold_cnt  <= '0;
            r_preempt   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt_vec   <= w_gnt_nxt;
            r_gnt_idx   <= w_idx_nxt;
            r_last_posn <= w_last_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_preempt   <= w_preempt_nxt;
        end
    end

    assign o_gnt_vec = r_gnt_vec;
    assign o_gnt_idx = r_gnt_idx;
    assign o_gnt_vld = |r_gnt_vec;
    assign o_preempt = r_preempt;

endmodule

// File: tb/tb_gnrl_rr_arb_lock.sv
// Directed bench for gnrl_rr_arb_lock: one instance without a hold limit,
// one with MAX_HOLD=8, sharing clock and reset.
module tb_gnrl_rr_arb_lock;

    logic       clk;
    logic       rst_n;
    logic [3:0] req0, end0, req8, end8;
    logic [3:0] gnt0, gnt8;
    logic [1:0] idx0, idx8;
    logic       vld0, vld8, pre0, pre8;
    int         checks;
    int         errors;

    gnrl_rr_arb_lock #(.N(4), .MAX_HOLD(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_req_vec(req0), .i_end_access_vec(end0),
        .o_gnt_vec(gnt0), .o_gnt_idx(idx0), .o_gnt_vld(vld0), .o_preempt(pre0)
    );

    gnrl_rr_arb_lock #(.N(4), .MAX_HOLD(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .i_req_vec(req8), .i_end_access_vec(end8),
        .o_gnt_vec(gnt8), .o_gnt_idx(idx8), .o_gnt_vld(vld8), .o_preempt(pre8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0  = 4'b1111;
        end0  = 4'b0000;
        req8  = 4'b0000;
        end8  = 4'b0000;
        #3;
        checks++; if (gnt0 !== 4'b0000) begin errors++; $display("FAIL rst_gnt0 got=%b exp=0000", gnt0); end
        checks++; if (idx0 !== 2'd0)    begin errors++; $display("FAIL rst_idx0 got=%0d exp=0", idx0); end
        checks++; if (vld0 !== 1'b0)    begin errors++; $display("FAIL rst_vld0 got=%b exp=0", vld0); end
        checks++; if (pre0 !== 1'b0)    begin errors++; $display("FAIL rst_pre0 got=%b exp=0", pre0); end
        checks++; if (gnt8 !== 4'b0000) begin errors++; $display("FAIL rst_gnt8 got=%b exp=0000", gnt8); end
        step();
        checks++; if (gnt0 !== 4'b0000) begin errors++; $display("FAIL rst_hold_gnt0 got=%b exp=0000", gnt0); end
        rst_n = 1'b1;
    endtask

    // Requests 1111 from reset: 0,1,2,3,0 each for two cycles, no gaps.
    task automatic test_priority();
        logic [3:0] exp;
        step();
        for (int i = 0; i < 5; i++) begin
            exp  = 4'b0001 << (i % 4);
            end0 = 4'b0000;
            checks++; if (gnt0 !== exp) begin errors++; $display("FAIL prio_gnt%0d_c1 got=%b exp=%b", i, gnt0, exp); end
            checks++; if (idx0 !== 2'(i % 4)) begin errors++; $display("FAIL prio_idx%0d got=%0d exp=%0d", i, idx0, i % 4); end
            checks++; if (vld0 !== 1'b1) begin errors++; $display("FAIL prio_vld%0d got=%b exp=1", i, vld0); end
            step();
            checks++; if (gnt0 !== exp) begin errors++; $display("FAIL prio_gnt%0d_c2 got=%b exp=%b", i, gnt0, exp); end
            end0 = exp;
            step();
        end
        end0 = 4'b0000;
    endtask

    // Holder is 1 (last winner 1); with 1001 the scan goes 2,3 -> 3, then 0.
    task automatic test_rotation();
        checks++; if (gnt0 !== 4'b0010) begin errors++; $display("FAIL rot_start got=%b exp=0010", gnt0); end
        req0 = 4'b1001;
        step();
        checks++; if (gnt0 !== 4'b1000) begin errors++; $display("FAIL rot_to3 got=%b exp=1000", gnt0); end
        checks++; if (idx0 !== 2'd3)    begin errors++; $display("FAIL rot_idx3 got=%0d exp=3", idx0); end
        end0 = 4'b1000;
        step();
        end0 = 4'b0000;
        checks++; if (gnt0 !== 4'b0001) begin errors++; $display("FAIL rot_to0 got=%b exp=0001", gnt0); end
        checks++; if (idx0 !== 2'd0)    begin errors++; $display("FAIL rot_idx0 got=%0d exp=0", idx0); end
    endtask

    task automatic test_abandon();
        req0 = 4'b0000;
        step();
        checks++; if (gnt0 !== 4'b0000) begin errors++; $display("FAIL aband_gnt got=%b exp=0000", gnt0); end
        checks++; if (vld0 !== 1'b0)    begin errors++; $display("FAIL aband_vld got=%b exp=0", vld0); end
        step();
        checks++; if (gnt0 !== 4'b0000) begin errors++; $display("FAIL aband_idle got=%b exp=0000", gnt0); end
        req0 = 4'b0001;
        step();
        checks++; if (gnt0 !== 4'b0001) begin errors++; $display("FAIL aband_regrant got=%b exp=0001", gnt0); end
        checks++; if (vld0 !== 1'b1)    begin errors++; $display("FAIL aband_vld1 got=%b exp=1", vld0); end
    endtask

    task automatic test_preempt();
        req8 = 4'b0100;
        step();
        for (int c = 0; c < 8; c++) begin
            checks++; if (gnt8 !== 4'b0100) begin errors++; $display("FAIL pre_hold_c%0d got=%b exp=0100", c, gnt8); end
            checks++; if (pre8 !== 1'b0)    begin errors++; $display("FAIL pre_low_c%0d got=%b exp=0", c, pre8); end
            if (c == 0) req8 = 4'b0101;
            step();
        end
        checks++; if (gnt8 !== 4'b0001) begin errors++; $display("FAIL pre_switch got=%b exp=0001", gnt8); end
        checks++; if (pre8 !== 1'b1)    begin errors++; $display("FAIL pre_pulse got=%b exp=1", pre8); end
        // 0 abandons, 2 is picked back up; no preempt for an abandon.
        req8 = 4'b0100;
        step();
        checks++; if (pre8 !== 1'b0) begin errors++; $display("FAIL pre_clear got=%b exp=0", pre8); end
        for (int c = 0; c < 8; c++) begin
            checks++; if (gnt8 !== 4'b0100) begin errors++; $display("FAIL pre2_hold_c%0d got=%b exp=0100", c, gnt8); end
            step();
        end
        checks++; if (gnt8 !== 4'b0000) begin errors++; $display("FAIL pre2_idle got=%b exp=0000", gnt8); end
        checks++; if (pre8 !== 1'b1)    begin errors++; $display("FAIL pre2_pulse got=%b exp=1", pre8); end
        step();
        checks++; if (gnt8 !== 4'b0100) begin errors++; $display("FAIL pre2_regrant got=%b exp=0100", gnt8); end
        checks++; if (pre8 !== 1'b0)    begin errors++; $display("FAIL pre2_clear got=%b exp=0", pre8); end
    endtask

    // Holder 1 with a foreign strobe and churn on requester 3: the grant must
    // still end exactly 8 cycles in, proving the counter kept running.
    task automatic test_foreign_strobe();
        req8 = 4'b0010;
        step();
        end8 = 4'b1000;
        for (int c = 0; c < 8; c++) begin
            checks++; if (gnt8 !== 4'b0010) begin errors++; $display("FAIL fs_hold_c%0d got=%b exp=0010", c, gnt8); end
            if (c == 3) req8 = 4'b1010;
            if (c == 5) req8 = 4'b0010;
            step();
        end
        checks++; if (gnt8 !== 4'b0000) begin errors++; $display("FAIL fs_end got=%b exp=0000", gnt8); end
        checks++; if (pre8 !== 1'b1)    begin errors++; $display("FAIL fs_pulse got=%b exp=1", pre8); end
        req8 = 4'b0000;
        end8 = 4'b0000;
    endtask

    task automatic test_async_reset();
        req0 = 4'b0000;
        step();
        req0 = 4'b0110;
        step();
        checks++; if (gnt0 !== 4'b0010) begin errors++; $display("FAIL ar_busy got=%b exp=0010", gnt0); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (gnt0 !== 4'b0000) begin errors++; $display("FAIL ar_gnt got=%b exp=0000", gnt0); end
        checks++; if (idx0 !== 2'd0)    begin errors++; $display("FAIL ar_idx got=%0d exp=0", idx0); end
        checks++; if (vld0 !== 1'b0)    begin errors++; $display("FAIL ar_vld got=%b exp=0", vld0); end
        req0 = 4'b0111;
        step();
        checks++; if (gnt0 !== 4'b0000) begin errors++; $display("FAIL ar_held got=%b exp=0000", gnt0); end
        rst_n = 1'b1;
        step();
        checks++; if (gnt0 !== 4'b0001) begin errors++; $display("FAIL ar_prio0 got=%b exp=0001", gnt0); end
        checks++; if (idx0 !== 2'd0)    begin errors++; $display("FAIL ar_prio_idx got=%0d exp=0", idx0); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_priority();
        test_rotation();
        test_abandon();
        test_preempt();
        test_foreign_strobe();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
